// File: rtl/cluster_pwr_seq.sv
// Power, clock, isolation and reset sequencer for NB_CLUSTERS cluster domains.
// One Moore FSM per cluster; power-up grants are serialised round-robin.
module cluster_pwr_seq #(
  parameter int unsigned                NB_CLUSTERS       = 2,
  parameter int unsigned                BOOT_ADDR_WIDTH   = 64,
  parameter logic [BOOT_ADDR_WIDTH-1:0] BOOT_ADDR_DEFAULT = 'h1C00_8000,
  parameter int unsigned                ISO_CYCLES        = 4,
  parameter int unsigned                RST_CYCLES        = 8,
  parameter int unsigned                TIMEOUT_CYCLES    = 1024
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic [NB_CLUSTERS-1:0]                      on_req_i,
  input  logic [NB_CLUSTERS-1:0]                      off_req_i,
  input  logic [NB_CLUSTERS-1:0]                      err_clr_i,
  input  logic [NB_CLUSTERS-1:0][BOOT_ADDR_WIDTH-1:0] boot_addr_i,
  input  logic [NB_CLUSTERS-1:0]                      pow_ack_i,
  input  logic [NB_CLUSTERS-1:0]                      cluster_busy_i,
  output logic [NB_CLUSTERS-1:0]                      cluster_pow_o,
  output logic [NB_CLUSTERS-1:0]                      cluster_clk_en_o,
  output logic [NB_CLUSTERS-1:0]                      cluster_iso_o,
  output logic [NB_CLUSTERS-1:0]                      cluster_rstn_o,
  output logic [NB_CLUSTERS-1:0]                      cluster_fetch_enable_o,
  output logic [NB_CLUSTERS-1:0][BOOT_ADDR_WIDTH-1:0] cluster_boot_addr_o,
  output logic [NB_CLUSTERS-1:0][2:0]                 state_o,
  output logic [NB_CLUSTERS-1:0]                      done_irq_o,
  output logic [NB_CLUSTERS-1:0]                      err_irq_o
);

  localparam int unsigned MAX_A   = (TIMEOUT_CYCLES > ISO_CYCLES) ? TIMEOUT_CYCLES : ISO_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_A > RST_CYCLES) ? MAX_A : RST_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned PTR_W   = (NB_CLUSTERS > 1) ? $clog2(NB_CLUSTERS) : 1;

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_WAIT_PWR = 3'd1,
    S_CLK_ON   = 3'd2,
    S_RST      = 3'd3,
    S_RUN      = 3'd4,
    S_DRAIN    = 3'd5,
    S_PWR_DN   = 3'd6,
    S_ERR      = 3'd7
  } state_e;

  state_e                                      state_q [NB_CLUSTERS];
  state_e                                      state_d [NB_CLUSTERS];
  logic [CNT_W-1:0]                            cnt_q   [NB_CLUSTERS];
  logic [CNT_W-1:0]                            cnt_d   [NB_CLUSTERS];
  logic [NB_CLUSTERS-1:0]                      pend_q, pend_d;
  logic [NB_CLUSTERS-1:0]                      pow_q, pow_d, clk_en_q, clk_en_d, iso_q, iso_d;
  logic [NB_CLUSTERS-1:0]                      rstn_q, rstn_d, fetch_q, fetch_d;
  logic [NB_CLUSTERS-1:0]                      done_q, done_d, err_q, err_d;
  logic [NB_CLUSTERS-1:0][BOOT_ADDR_WIDTH-1:0] boot_q, boot_d;
  logic [PTR_W-1:0]                            ptr_q, ptr_d;
  logic [NB_CLUSTERS-1:0]                      on_ok, off_ok, eligible, grant_oh;

  // Simultaneous on/off requests cancel each other; a cancelling cluster is not grantable.
  assign on_ok    = on_req_i & ~off_req_i;
  assign off_ok   = off_req_i & ~on_req_i;
  assign eligible = pend_q & ~off_ok;

  always_comb begin
    logic             any_wait;
    logic [PTR_W-1:0] idx;
    any_wait = 1'b0;
    idx      = '0;
    grant_oh = '0;
    ptr_d    = ptr_q;
    for (int unsigned i = 0; i < NB_CLUSTERS; i++) begin
      if (state_q[i] == S_WAIT_PWR) any_wait = 1'b1;
    end
    for (int unsigned k = 0; k < NB_CLUSTERS; k++) begin
      idx = PTR_W'(((ptr_q + k) >= NB_CLUSTERS) ? (ptr_q + k - NB_CLUSTERS) : (ptr_q + k));
      if (!any_wait && (grant_oh == '0) && eligible[idx]) begin
        grant_oh[idx] = 1'b1;
        ptr_d         = ((32'(idx) + 1) >= NB_CLUSTERS) ? '0 : idx + 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    boot_d   = boot_q;
    pow_d    = '0;
    clk_en_d = '0;
    iso_d    = '1;
    rstn_d   = '0;
    fetch_d  = '0;
    done_d   = '0;
    err_d    = '0;
    for (int unsigned i = 0; i < NB_CLUSTERS; i++) begin
      case (state_q[i])
        S_OFF: begin
          if (on_ok[i]) begin
            pend_d[i] = 1'b1;
            boot_d[i] = boot_addr_i[i];
          end else if (off_ok[i]) begin
            pend_d[i] = 1'b0;
          end
          if (grant_oh[i]) begin
            state_d[i] = S_WAIT_PWR;
            pend_d[i]  = 1'b0;
          end
        end
        S_WAIT_PWR: begin
          if (pow_ack_i[i])                              state_d[i] = S_CLK_ON;
          else if (cnt_q[i] == CNT_W'(TIMEOUT_CYCLES))   state_d[i] = S_ERR;
        end
        S_CLK_ON: if (cnt_q[i] == CNT_W'(ISO_CYCLES - 1)) state_d[i] = S_RST;
        S_RST:    if (cnt_q[i] == CNT_W'(RST_CYCLES - 1)) state_d[i] = S_RUN;
        S_RUN:    if (off_ok[i])                          state_d[i] = S_DRAIN;
        S_DRAIN: begin
          if (!cluster_busy_i[i])                        state_d[i] = S_PWR_DN;
          else if (cnt_q[i] == CNT_W'(TIMEOUT_CYCLES))   state_d[i] = S_ERR;
        end
        S_PWR_DN: begin
          if (!pow_ack_i[i])                             state_d[i] = S_OFF;
          else if (cnt_q[i] == CNT_W'(TIMEOUT_CYCLES))   state_d[i] = S_ERR;
        end
        S_ERR: begin
          if (err_clr_i[i]) begin
            state_d[i] = S_OFF;
            pend_d[i]  = 1'b0;
          end
        end
      endcase

      if (state_d[i] != state_q[i]) begin
        cnt_d[i] = '0;
      end else if ((state_q[i] inside {S_WAIT_PWR, S_CLK_ON, S_RST, S_DRAIN, S_PWR_DN}) &&
                   (cnt_q[i] != CNT_W'(CNT_MAX))) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end

      // Outputs are decoded from the next state so they register alongside it.
      case (state_d[i])
        S_WAIT_PWR: pow_d[i] = 1'b1;
        S_CLK_ON: begin
          pow_d[i]    = 1'b1;
          clk_en_d[i] = 1'b1;
        end
        S_RST: begin
          pow_d[i]    = 1'b1;
          clk_en_d[i] = 1'b1;
          iso_d[i]    = 1'b0;
        end
        S_RUN: begin
          pow_d[i]    = 1'b1;
          clk_en_d[i] = 1'b1;
          iso_d[i]    = 1'b0;
          rstn_d[i]   = 1'b1;
          fetch_d[i]  = 1'b1;
        end
        S_DRAIN: begin
          pow_d[i]    = 1'b1;
          clk_en_d[i] = 1'b1;
          iso_d[i]    = 1'b0;
          rstn_d[i]   = 1'b1;
        end
        default: ;
      endcase

      done_d[i] = (state_d[i] != state_q[i]) &&
                  ((state_d[i] == S_RUN) || ((state_d[i] == S_OFF) && (state_q[i] == S_PWR_DN)));
      err_d[i]  = (state_d[i] != state_q[i]) && (state_d[i] == S_ERR);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NB_CLUSTERS; i++) begin
        state_q[i] <= S_OFF;
        cnt_q[i]   <= '0;
      end
      pend_q   <= '0;
      pow_q    <= '0;
      clk_en_q <= '0;
      iso_q    <= '1;
      rstn_q   <= '0;
      fetch_q  <= '0;
      done_q   <= '0;
      err_q    <= '0;
      boot_q   <= {NB_CLUSTERS{BOOT_ADDR_DEFAULT}};
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      pow_q    <= pow_d;
      clk_en_q <= clk_en_d;
      iso_q    <= iso_d;
      rstn_q   <= rstn_d;
      fetch_q  <= fetch_d;
      done_q   <= done_d;
      err_q    <= err_d;
      boot_q   <= boot_d;
      ptr_q    <= ptr_d;
    end
  end

  always_comb begin
    state_o = '0;
    for (int unsigned i = 0; i < NB_CLUSTERS; i++) state_o[i] = state_q[i];
  end

  assign cluster_pow_o          = pow_q;
  assign cluster_clk_en_o       = clk_en_q;
  assign cluster_iso_o          = iso_q;
  assign cluster_rstn_o         = rstn_q;
  assign cluster_fetch_enable_o = fetch_q;
  assign cluster_boot_addr_o    = boot_q;
  assign done_irq_o             = done_q;
  assign err_irq_o              = err_q;

endmodule

// File: tb/tb_cluster_pwr_seq.sv
// Directed bench for cluster_pwr_seq: one instance with default timeout,
// a second with a short timeout for the error path.
module tb_cluster_pwr_seq;

  localparam logic [63:0] BOOT_DEF = 64'h1C00_8000;

  logic clk = 1'b0;
  logic rst;

  logic [1:0]       on_req, off_req, err_clr, pow_ack, busy;
  logic [1:0][63:0] boot_in;
  logic [1:0]       pow, clk_en, iso, rstn, fetch, done_irq, err_irq;
  logic [1:0][63:0] boot_out;
  logic [1:0][2:0]  state;

  logic [1:0]       t_on, t_off, t_clr, t_ack, t_busy;
  logic [1:0][63:0] t_boot_in;
  logic [1:0]       t_pow, t_clk_en, t_iso, t_rstn, t_fetch, t_done, t_err;
  logic [1:0][63:0] t_boot_out;
  logic [1:0][2:0]  t_state;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cluster_pwr_seq #(
    .NB_CLUSTERS(2), .BOOT_ADDR_WIDTH(64), .BOOT_ADDR_DEFAULT(BOOT_DEF),
    .ISO_CYCLES(4), .RST_CYCLES(8), .TIMEOUT_CYCLES(1024)
  ) u_dut (
    .clk_i(clk), .rst_i(rst), .on_req_i(on_req), .off_req_i(off_req), .err_clr_i(err_clr),
    .boot_addr_i(boot_in), .pow_ack_i(pow_ack), .cluster_busy_i(busy),
    .cluster_pow_o(pow), .cluster_clk_en_o(clk_en), .cluster_iso_o(iso),
    .cluster_rstn_o(rstn), .cluster_fetch_enable_o(fetch), .cluster_boot_addr_o(boot_out),
    .state_o(state), .done_irq_o(done_irq), .err_irq_o(err_irq)
  );

  cluster_pwr_seq #(
    .NB_CLUSTERS(2), .BOOT_ADDR_WIDTH(64), .BOOT_ADDR_DEFAULT(BOOT_DEF),
    .ISO_CYCLES(4), .RST_CYCLES(8), .TIMEOUT_CYCLES(16)
  ) u_dut_to (
    .clk_i(clk), .rst_i(rst), .on_req_i(t_on), .off_req_i(t_off), .err_clr_i(t_clr),
    .boot_addr_i(t_boot_in), .pow_ack_i(t_ack), .cluster_busy_i(t_busy),
    .cluster_pow_o(t_pow), .cluster_clk_en_o(t_clk_en), .cluster_iso_o(t_iso),
    .cluster_rstn_o(t_rstn), .cluster_fetch_enable_o(t_fetch), .cluster_boot_addr_o(t_boot_out),
    .state_o(t_state), .done_irq_o(t_done), .err_irq_o(t_err)
  );

  function automatic logic [4:0] outs(input int i);
    return {pow[i], clk_en[i], iso[i], rstn[i], fetch[i]};
  endfunction

  function automatic logic [4:0] t_outs(input int i);
    return {t_pow[i], t_clk_en[i], t_iso[i], t_rstn[i], t_fetch[i]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    on_req = '0; off_req = '0; err_clr = '0; pow_ack = '0; busy = '0; boot_in = '0;
    t_on = '0; t_off = '0; t_clr = '0; t_ack = '0; t_busy = '0; t_boot_in = '0;
    step(2);

    chk("rst_state0", 64'(state[0]), 0);
    chk("rst_state1", 64'(state[1]), 0);
    chk("rst_outs0", 64'(outs(0)), 64'b00100);
    chk("rst_outs1", 64'(outs(1)), 64'b00100);
    chk("rst_boot0", boot_out[0], BOOT_DEF);
    chk("rst_irqs", 64'({done_irq, err_irq}), 0);
    rst = 1'b0;

    // Contention: both request together, pointer at 0 (cycle 0 = now)
    on_req = 2'b11;
    boot_in[0] = 64'hA0A0_0000_0000_1000;
    boot_in[1] = 64'hB0B0_0000_0000_2000;
    step(); on_req = '0;                                  // cycle 1
    chk("cont_c1_s0", 64'(state[0]), 0);
    step();                                               // cycle 2
    chk("cont_c2_s0", 64'(state[0]), 1);
    chk("cont_c2_s1", 64'(state[1]), 0);
    chk("cont_c2_outs0", 64'(outs(0)), 64'b10100);
    pow_ack[0] = 1'b1;
    step();                                               // cycle 3
    chk("cont_c3_s0", 64'(state[0]), 2);
    chk("cont_c3_s1", 64'(state[1]), 0);
    step();                                               // cycle 4
    chk("cont_c4_s1", 64'(state[1]), 1);
    chk("cont_boot1", boot_out[1], 64'hB0B0_0000_0000_2000);
    step(3);                                              // cycle 7
    chk("cont_c7_s0", 64'(state[0]), 3);
    chk("cont_c7_outs0", 64'(outs(0)), 64'b11000);
    off_req[1] = 1'b1;                                    // ignored in WAIT_PWR
    step(); off_req = '0;                                 // cycle 8
    chk("filt_off_wait", 64'(state[1]), 1);

    // Synchronous reset while cluster 0 sits in RST
    rst = 1'b1; pow_ack = 2'b11;
    step();
    chk("midrst_s0", 64'(state[0]), 0);
    chk("midrst_s1", 64'(state[1]), 0);
    chk("midrst_outs0", 64'(outs(0)), 64'b00100);
    chk("midrst_outs1", 64'(outs(1)), 64'b00100);
    chk("midrst_boot0", boot_out[0], BOOT_DEF);
    chk("midrst_boot1", boot_out[1], BOOT_DEF);
    rst = 1'b0; pow_ack = '0;

    // Single power-up of cluster 0 (t = 0 now)
    on_req[0] = 1'b1;
    boot_in[0] = 64'hDEAD_BEEF_0000_1000;
    step(); on_req = '0;                                  // t1
    chk("up_t1_s0", 64'(state[0]), 0);
    step();                                               // t2
    chk("up_t2_s0", 64'(state[0]), 1);
    chk("up_t2_outs", 64'(outs(0)), 64'b10100);
    step(3);                                              // t5
    chk("up_t5_s0", 64'(state[0]), 1);
    pow_ack[0] = 1'b1;
    step();                                               // t6
    chk("up_t6_s0", 64'(state[0]), 2);
    chk("up_t6_outs", 64'(outs(0)), 64'b11100);
    step(3);                                              // t9
    chk("up_t9_s0", 64'(state[0]), 2);
    step();                                               // t10
    chk("up_t10_s0", 64'(state[0]), 3);
    chk("up_t10_outs", 64'(outs(0)), 64'b11000);
    step(7);                                              // t17
    chk("up_t17_s0", 64'(state[0]), 3);
    chk("up_t17_done", 64'(done_irq[0]), 0);
    step();                                               // t18
    chk("up_t18_s0", 64'(state[0]), 4);
    chk("up_t18_outs", 64'(outs(0)), 64'b11011);
    chk("up_t18_done", 64'(done_irq), 64'b01);
    chk("up_boot0", boot_out[0], 64'hDEAD_BEEF_0000_1000);
    step();                                               // t19
    chk("up_t19_done", 64'(done_irq[0]), 0);

    // Filtering: on_req in RUN; simultaneous on/off in OFF
    on_req = 2'b11; off_req[1] = 1'b1;
    step(); on_req = '0; off_req = '0;                    // t20
    chk("filt_on_run", 64'(state[0]), 4);
    step();                                               // t21
    chk("filt_onoff_off", 64'(state[1]), 0);

    // Cancel a pending request with off_req
    on_req[1] = 1'b1;
    step(); on_req = '0; off_req[1] = 1'b1;               // t22
    step(); off_req = '0;                                 // t23
    chk("cancel_t23", 64'(state[1]), 0);
    step(2);                                              // t25
    chk("cancel_t25", 64'(state[1]), 0);

    // Power-down with busy held for 20 cycles
    off_req[0] = 1'b1; busy[0] = 1'b1;
    step(); off_req = '0;                                 // t26
    chk("dn_drain_s0", 64'(state[0]), 5);
    chk("dn_drain_outs", 64'(outs(0)), 64'b11010);
    step(19);                                             // t45
    chk("dn_busy_s0", 64'(state[0]), 5);
    busy[0] = 1'b0;
    step();                                               // t46
    chk("dn_pwrdn_s0", 64'(state[0]), 6);
    chk("dn_pwrdn_outs", 64'(outs(0)), 64'b00100);
    chk("dn_pwrdn_done", 64'(done_irq[0]), 0);
    step(2);                                              // t48
    chk("dn_hold_s0", 64'(state[0]), 6);
    pow_ack[0] = 1'b0;
    step();                                               // t49
    chk("dn_off_s0", 64'(state[0]), 0);
    chk("dn_off_done", 64'(done_irq), 64'b01);
    step();
    chk("dn_done_clr", 64'(done_irq[0]), 0);

    // Timeout on the short-timeout instance (s = 0 now)
    t_on[0] = 1'b1;
    step(); t_on = '0;                                    // s1
    step();                                               // s2: WAIT_PWR entry
    chk("to_s2", 64'(t_state[0]), 1);
    step(16);                                             // s18
    chk("to_s18", 64'(t_state[0]), 1);
    chk("to_s18_err", 64'(t_err[0]), 0);
    step();                                               // s19
    chk("to_s19", 64'(t_state[0]), 7);
    chk("to_s19_err", 64'(t_err), 64'b01);
    chk("to_s19_outs", 64'(t_outs(0)), 64'b00100);
    step();                                               // s20
    chk("to_s20_err", 64'(t_err[0]), 0);
    t_clr[0] = 1'b1;
    step(); t_clr = '0;                                   // s21
    chk("to_clr", 64'(t_state[0]), 0);
    t_on[0] = 1'b1;
    step(); t_on = '0;                                    // s22
    step();                                               // s23
    chk("to_reup_wait", 64'(t_state[0]), 1);
    t_ack[0] = 1'b1;
    step();                                               // s24
    chk("to_reup_clkon", 64'(t_state[0]), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cluster_pwr_seq.md
# cluster_pwr_seq

Power, clock, isolation and reset sequencer for up to NB_CLUSTERS cluster domains, sitting in the SoC domain between the FC-side control registers and the cluster ports (power switch, clock enable, isolation, reset, fetch enable, boot address). It generalises the single-cluster static control path to N clusters, each with its own state machine. It adds a timed power-up/power-down sequence, a drain handshake on `cluster_busy`, timeout-based error detection, and round-robin serialisation of power-up to bound inrush current.

## Interface
- NB_CLUSTERS, 2: number of cluster domains (1..8)
- BOOT_ADDR_WIDTH, 64: boot address width
- BOOT_ADDR_DEFAULT, 64'h1C00_8000: boot address reset value
- ISO_CYCLES, 4: cycles with clock running and isolation held before isolation release (>=1)
- RST_CYCLES, 8: cycles reset held low after isolation release (>=1)
- TIMEOUT_CYCLES, 1024: max cycles waiting on ack/busy; counter width $clog2(TIMEOUT_CYCLES+1)

Ports:
- clk_i  in  1  clock; single clock domain
- rst_i  in  1  reset, synchronous, active-high
- on_req_i  in  NB_CLUSTERS  per-cluster power-on request pulse
- off_req_i  in  NB_CLUSTERS  per-cluster power-off request pulse
- err_clr_i  in  NB_CLUSTERS  per-cluster error clear pulse
- boot_addr_i  in  NB_CLUSTERS x BOOT_ADDR_WIDTH  boot address, captured on accepted on_req
- pow_ack_i  in  NB_CLUSTERS  power switch acknowledge (high = domain powered)
- cluster_busy_i  in  NB_CLUSTERS  cluster busy
- cluster_pow_o  out  NB_CLUSTERS  power switch enable
- cluster_clk_en_o  out  NB_CLUSTERS  cluster clock gate enable
- cluster_iso_o  out  NB_CLUSTERS  isolation enable (1 = isolated)
- cluster_rstn_o  out  NB_CLUSTERS  cluster reset, active-low
- cluster_fetch_enable_o  out  NB_CLUSTERS  fetch enable
- cluster_boot_addr_o  out  NB_CLUSTERS x BOOT_ADDR_WIDTH  registered boot address
- state_o  out  NB_CLUSTERS x 3  FSM state: OFF=0, WAIT_PWR=1, CLK_ON=2, RST=3, RUN=4, DRAIN=5, PWR_DN=6, ERR=7
- done_irq_o  out  NB_CLUSTERS  1-cycle pulse on entry to RUN or OFF (from PWR_DN)
- err_irq_o  out  NB_CLUSTERS  1-cycle pulse on entry to ERR

## Operation
- Per-cluster Moore FSM. All outputs registered. Outputs per state are listed as pow/clk_en/iso/rstn/fetch.
- Reset values, all clusters: state OFF, outputs 0/0/1/0/0, boot address BOOT_ADDR_DEFAULT, irqs 0, pending 0, round-robin pointer 0.
- OFF (0/0/1/0/0):
  - on_req sets the pending bit and captures boot_addr_i.
  - A granted pending cluster goes to WAIT_PWR and clears pending.
- Arbiter:
  - At most one cluster in WAIT_PWR at any time.
  - When none is in WAIT_PWR, grant the lowest pending index at or after the pointer (wrapping).
  - Pointer moves to granted index+1 mod NB_CLUSTERS.
- WAIT_PWR (1/0/1/0/0): pow_ack_i=1 -> CLK_ON.
- CLK_ON (1/1/1/0/0): after ISO_CYCLES cycles -> RST.
- RST (1/1/0/0/0): after RST_CYCLES cycles -> RUN.
- RUN (1/1/0/1/1): off_req -> DRAIN.
- DRAIN (1/1/0/1/0): cluster_busy_i=0 -> PWR_DN.
- PWR_DN (0/0/1/0/0): pow_ack_i=0 -> OFF.
- ERR (0/0/1/0/0): err_clr -> OFF; pending cleared.
- Timeout: counter cleared on every state entry, incremented in WAIT_PWR/DRAIN/PWR_DN; reaching TIMEOUT_CYCLES with the exit condition false -> ERR.
- Request filtering:
  - on_req is ignored outside OFF.
  - off_req is ignored outside RUN.
  - on_req and off_req in the same cycle: both ignored.
  - off_req in OFF with pending set: clears pending (cancel).
  - err_clr is ignored outside ERR.

## Timing
- on_req at cycle t (idle arbiter): pending=1 at t+1, state WAIT_PWR and pow=1 at t+2.
- Ack at cycle a in WAIT_PWR: CLK_ON from a+1, RST from a+1+ISO_CYCLES, RUN (rstn=1, fetch=1, done_irq) from a+1+ISO_CYCLES+RST_CYCLES.
- off_req at t in RUN: DRAIN (fetch=0) at t+1. busy low observed at b: PWR_DN at b+1, with iso=1, rstn=0, clk_en=0, pow=0 all in the same cycle.
- Timeout: ERR is entered exactly TIMEOUT_CYCLES+1 cycles after entering the waiting state.
- Arbiter: a second cluster's pending grant is issued in the cycle after the first leaves WAIT_PWR, so its WAIT_PWR starts one cycle after the first's CLK_ON entry.
- rst_i mid-sequence: all clusters return to reset values next edge, regardless of pow_ack_i.

## Test plan
- Single power-up, ISO_CYCLES=4, RST_CYCLES=8: on_req[0] at t=0, pow_ack[0] rises t=5 -> pow at t=2, CLK_ON t=6, RST t=10, RUN with fetch=1, done_irq pulse at t=18, boot_addr_o = captured value.
- Contention: on_req[0] and on_req[1] same cycle, pointer 0 -> cluster 0 WAIT_PWR first; cluster 1 WAIT_PWR exactly one cycle after cluster 0 enters CLK_ON; pointer then 0 (wraps after 1).
- Power-down with busy: in RUN, off_req; busy held 20 cycles -> fetch=0 next cycle, PWR_DN one cycle after busy falls, OFF plus done_irq one cycle after ack falls.
- Timeout: on_req with pow_ack stuck 0, TIMEOUT_CYCLES=16 -> ERR plus err_irq at WAIT_PWR entry+17; err_clr -> OFF next cycle; further on_req works.
- Filtering: on_req in RUN, off_req in WAIT_PWR, simultaneous on/off in OFF -> no state change; off_req while pending -> pending cleared, never reaches WAIT_PWR.
- rst_i asserted during RST state -> next cycle state OFF, outputs 0/0/1/0/0, boot address = BOOT_ADDR_DEFAULT.
